// File: rtl/sfu_rr_arbiter_if.sv
// Requester-side and SFU-side handshake bundle for the SFU round-robin arbiter.
// Signal names are written from the arbiter's point of view.
interface sfu_rr_arbiter_if #(
    parameter int NUM_REQ    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                 req_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_i;
    logic [NUM_REQ-1:0]                 gnt_o;
    logic                               req_o;
    logic                               gnt_i;
    logic [DATA_WIDTH-1:0]              data_o;
    logic [IDX_WIDTH-1:0]               idx_o;

    modport slave  (input  req_i, data_i, gnt_i, output gnt_o, req_o, data_o, idx_o);
    modport master (output req_i, data_i, gnt_i, input  gnt_o, req_o, data_o, idx_o);
endinterface

// File: rtl/sfu_rr_arbiter.sv
// Round-robin arbiter sharing one SFU operand port among NUM_REQ issue queues.
// Selection is held across a valid/ready stall; the pointer moves only on a handshake.
module sfu_rr_lzc #(
    parameter int WIDTH     = 8,
    parameter int MODE      = 0,
    parameter int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);
    // MODE 0 counts trailing zeros, otherwise leading zeros
    always_comb begin
        cnt_o = '0;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
        end
    end

    assign empty_o = ~|in_i;
endmodule

module sfu_rr_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             flush_i,
    sfu_rr_arbiter_if.slave arb
);
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic                 lock_q, lock_d;
    logic [IDX_WIDTH-1:0] lidx_q, lidx_d;

    logic [NUM_REQ-1:0]   mask, req_m;
    logic [IDX_WIDTH-1:0] tz_m, tz_u, sel;
    logic                 m_empty, u_empty;
    logic                 vld, hs;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            mask[i] = (i >= int'(ptr_q));
    end

    assign req_m = arb.req_i & mask;

    sfu_rr_lzc #(.WIDTH(NUM_REQ), .MODE(0), .CNT_WIDTH(IDX_WIDTH)) u_tz_m (
        .in_i(req_m), .cnt_o(tz_m), .empty_o(m_empty)
    );
    sfu_rr_lzc #(.WIDTH(NUM_REQ), .MODE(0), .CNT_WIDTH(IDX_WIDTH)) u_tz_u (
        .in_i(arb.req_i), .cnt_o(tz_u), .empty_o(u_empty)
    );

    // Nothing at or above the pointer wraps to the lowest requester
    assign sel = lock_q ? lidx_q : (m_empty ? tz_u : tz_m);
    assign vld = lock_q ? arb.req_i[lidx_q] : ~u_empty;
    assign hs  = vld & arb.gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        lock_d = lock_q;
        lidx_d = lidx_q;
        if (hs) begin
            ptr_d  = (sel == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            lock_d = 1'b0;
        end else if (vld) begin
            if (!lock_q) begin
                lock_d = 1'b1;
                lidx_d = sel;
            end
        end else if (lock_q) begin
            // locked requester withdrew: release without moving the pointer
            lock_d = 1'b0;
        end
        if (flush_i) begin
            ptr_d  = '0;
            lock_d = 1'b0;
            lidx_d = '0;
        end
    end

    always_comb begin
        arb.gnt_o      = '0;
        arb.gnt_o[sel] = hs;
        arb.req_o      = vld;
        arb.idx_o      = sel;
        arb.data_o     = arb.data_i[sel];
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_proto
        a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (arb.req_i[k] && !arb.gnt_o[k]) |=> (arb.req_i[k] && $stable(arb.data_i[k])))
            else $warning("protocol: requester %0d dropped request or changed data before grant", k);
    end
endmodule
